// File: rtl/ball_physics.sv
// Ball motion engine: serve placement, gravity integration on a fixed
// physics tick, and collision resolution against floor, players, net,
// walls and ceiling. Reports which side scored when the ball lands.
module ball_physics #(
  parameter int VBUF_W       = 320,
  parameter int VBUF_H       = 240,
  parameter int BALL_D       = 20,
  parameter int PLAYER_W     = 41,
  parameter int PLAYER_H     = 42,
  parameter int GROUND_Y     = 220,
  parameter int NET_X        = 158,
  parameter int NET_W        = 4,
  parameter int NET_TOP      = 140,
  parameter int SERVE_X_L    = 50,
  parameter int SERVE_X_R    = 250,
  parameter int SERVE_Y      = 40,
  parameter int TICK_DIV     = 1_666_667,
  parameter int GRAVITY      = 1,
  parameter int VMAX         = 8,
  parameter int HIT_VY       = 10,
  parameter int HIT_VX_MAX   = 6,
  parameter int HIT_COOLDOWN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  game_state,
  input  logic        serve_side,
  input  logic [11:0] npc_pos_x,
  input  logic [11:0] npc_pos_y,
  input  logic [11:0] player_pos_x,
  input  logic [11:0] player_pos_y,
  output logic [11:0] ball_pos_x,
  output logic [11:0] ball_pos_y,
  output logic        score_valid,
  output logic        score_side,
  output logic        ball_busy
);

  typedef enum logic [1:0] {SERVE, FLY, SCORED} state_t;
  typedef logic signed [13:0] s14_t;
  typedef logic signed [7:0]  s8_t;

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam int CD_W  = $clog2(HIT_COOLDOWN + 1);

  localparam logic [1:0] GS_SERVE = 2'd1;
  localparam logic [1:0] GS_PLAY  = 2'd2;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CD_W-1:0]  CD_ONE    = CD_W'(1);
  localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(HIT_COOLDOWN);

  localparam s14_t BALL_D_S      = s14_t'(BALL_D);
  localparam s14_t HALF_BALL_S   = s14_t'(BALL_D / 2);
  localparam s14_t HALF_PLAYER_S = s14_t'(PLAYER_W / 2);
  localparam s14_t HALF_SCREEN_S = s14_t'(VBUF_W / 2);
  localparam s14_t PLAYER_W_S    = s14_t'(PLAYER_W);
  localparam s14_t PLAYER_H_S    = s14_t'(PLAYER_H);
  localparam s14_t GROUND_S      = s14_t'(GROUND_Y);
  localparam s14_t NET_X_S       = s14_t'(NET_X);
  localparam s14_t NET_W_S       = s14_t'(NET_W);
  localparam s14_t NET_TOP_S     = s14_t'(NET_TOP);
  localparam s14_t NET_H_S       = s14_t'(GROUND_Y - NET_TOP);
  localparam s14_t X_MAX_S       = s14_t'(VBUF_W - BALL_D);
  localparam s14_t Y_MAX_S       = s14_t'(VBUF_H - BALL_D);
  localparam s14_t ZERO_S        = s14_t'(0);
  localparam s14_t HIT_VX_S      = s14_t'(HIT_VX_MAX);

  localparam s8_t GRAVITY_V = s8_t'(GRAVITY);
  localparam s8_t VMAX_V    = s8_t'(VMAX);
  localparam s8_t HIT_VY_V  = s8_t'(HIT_VY);

  localparam logic [11:0] SERVE_XL_P = 12'(SERVE_X_L);
  localparam logic [11:0] SERVE_XR_P = 12'(SERVE_X_R);
  localparam logic [11:0] SERVE_Y_P  = 12'(SERVE_Y);
  localparam logic [11:0] LAND_Y_P   = 12'(GROUND_Y - BALL_D);
  localparam logic [11:0] NET_REST_P = 12'(NET_TOP - BALL_D);

  state_t           state;
  logic [11:0]      pos_x, pos_y;
  s8_t              vx, vy;
  logic [CNT_W-1:0] tick_cnt;
  logic [CD_W-1:0]  cd_npc, cd_player;

  s14_t xs, ys, vxs, vys, nx, ny, npx, npy, ppx, ppy;
  s14_t cx, cy, hit_px, diff, hit_v;
  s8_t  grav_vy;
  logic hit_npc, hit_player, hit_net, tick;
  logic [11:0] serve_x;

  logic [11:0]     nxt_x, nxt_y;
  s8_t             nxt_vx, nxt_vy;
  logic            land, land_side;
  logic [CD_W-1:0] nxt_cd_npc, nxt_cd_player;

  function automatic s14_t clamp(input s14_t v, input s14_t lo, input s14_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic s8_t abs8(input s8_t v);
    return v[7] ? -v : v;
  endfunction

  // True when the ball box at (ax,ay) overlaps the box (bx,by,bw,bh).
  function automatic logic overlaps(input s14_t ax, input s14_t ay, input s14_t bx,
                                    input s14_t by, input s14_t bw, input s14_t bh);
    return (ax < bx + bw) && (bx < ax + BALL_D_S) &&
           (ay < by + bh) && (by < ay + BALL_D_S);
  endfunction

  assign xs  = {2'b00, pos_x};
  assign ys  = {2'b00, pos_y};
  assign vxs = {{6{vx[7]}}, vx};
  assign vys = {{6{vy[7]}}, vy};
  assign nx  = xs + vxs;
  assign ny  = ys + vys;
  assign npx = {2'b00, npc_pos_x};
  assign npy = {2'b00, npc_pos_y};
  assign ppx = {2'b00, player_pos_x};
  assign ppy = {2'b00, player_pos_y};

  assign tick    = (tick_cnt == TICK_LAST);
  assign serve_x = serve_side ? SERVE_XR_P : SERVE_XL_P;

  assign ball_pos_x = pos_x;
  assign ball_pos_y = pos_y;

  // Resolve the ball state one physics tick ahead; first matching rule wins.
  always_comb begin
    nxt_x         = pos_x;
    nxt_y         = pos_y;
    nxt_vx        = vx;
    nxt_vy        = vy;
    land          = 1'b0;
    land_side     = 1'b0;
    cx            = clamp(nx, ZERO_S, X_MAX_S);
    cy            = clamp(ny, ZERO_S, Y_MAX_S);
    hit_px        = npx;
    diff          = ZERO_S;
    hit_v         = ZERO_S;
    grav_vy       = vy + GRAVITY_V;
    nxt_cd_npc    = (cd_npc != '0) ? cd_npc - CD_ONE : '0;
    nxt_cd_player = (cd_player != '0) ? cd_player - CD_ONE : '0;
    hit_npc       = overlaps(nx, ny, npx, npy, PLAYER_W_S, PLAYER_H_S) && (cd_npc == '0);
    hit_player    = overlaps(nx, ny, ppx, ppy, PLAYER_W_S, PLAYER_H_S) && (cd_player == '0);
    hit_net       = overlaps(nx, ny, NET_X_S, NET_TOP_S, NET_W_S, NET_H_S);

    if (ny + BALL_D_S >= GROUND_S) begin
      land      = 1'b1;
      nxt_y     = LAND_Y_P;
      nxt_x     = cx[11:0];
      land_side = (cx + HALF_BALL_S < HALF_SCREEN_S);
    end else if (hit_npc || hit_player) begin
      hit_px = hit_npc ? npx : ppx;
      diff   = (nx + HALF_BALL_S) - (hit_px + HALF_PLAYER_S);
      hit_v  = clamp(diff >>> 2, -HIT_VX_S, HIT_VX_S);
      nxt_vx = hit_v[7:0];
      nxt_vy = -HIT_VY_V;
      nxt_x  = cx[11:0];
      nxt_y  = cy[11:0];
      if (hit_npc) nxt_cd_npc = CD_LOAD;
      else         nxt_cd_player = CD_LOAD;
    end else if (hit_net) begin
      if (ys + BALL_D_S <= NET_TOP_S) begin
        nxt_vy = -abs8(vy);
        nxt_y  = NET_REST_P;
        nxt_x  = nx[11:0];
      end else begin
        nxt_vx = -vx;
        nxt_y  = ny[11:0];
        nxt_vy = grav_vy;
      end
    end else begin
      if (nx < ZERO_S) begin
        nxt_x  = '0;
        nxt_vx = abs8(vx);
      end else if (nx > X_MAX_S) begin
        nxt_x  = X_MAX_S[11:0];
        nxt_vx = -abs8(vx);
      end else begin
        nxt_x = nx[11:0];
      end
      if (ny < ZERO_S) begin
        nxt_y  = '0;
        nxt_vy = abs8(vy);
      end else begin
        nxt_y  = ny[11:0];
        nxt_vy = (grav_vy > VMAX_V) ? VMAX_V : grav_vy;
      end
    end
  end

  // Serve/fly/scored sequencing with registered ball state and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= SERVE;
      pos_x       <= SERVE_XL_P;
      pos_y       <= SERVE_Y_P;
      vx          <= '0;
      vy          <= '0;
      tick_cnt    <= '0;
      cd_npc      <= '0;
      cd_player   <= '0;
      score_valid <= 1'b0;
      score_side  <= 1'b0;
      ball_busy   <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      if (game_state == GS_SERVE) begin
        state     <= SERVE;
        pos_x     <= serve_x;
        pos_y     <= SERVE_Y_P;
        vx        <= '0;
        vy        <= '0;
        tick_cnt  <= '0;
        cd_npc    <= '0;
        cd_player <= '0;
        ball_busy <= 1'b0;
      end else begin
        case (state)
          SERVE: begin
            pos_x <= serve_x;
            pos_y <= SERVE_Y_P;
            if (game_state == GS_PLAY) begin
              state     <= FLY;
              ball_busy <= 1'b1;
            end
          end
          FLY: begin
            if (game_state == GS_PLAY) begin
              if (tick) begin
                tick_cnt  <= '0;
                pos_x     <= nxt_x;
                pos_y     <= nxt_y;
                vx        <= nxt_vx;
                vy        <= nxt_vy;
                cd_npc    <= nxt_cd_npc;
                cd_player <= nxt_cd_player;
                if (land) begin
                  state       <= SCORED;
                  score_valid <= 1'b1;
                  score_side  <= land_side;
                  ball_busy   <= 1'b0;
                end
              end else begin
                tick_cnt <= tick_cnt + CNT_ONE;
              end
            end
          end
          SCORED: begin
            state <= SCORED;
          end
          default: begin
            state     <= SERVE;
            ball_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
